// File: rtl/somador_c2_seq_if.sv
// somador_c2_seq_if: request/result bundle for the bit-serial two's-complement
// adder/subtractor.
//   start, sub, a, b : request from the master (sampled by the slave with start)
//   busy, done       : operation status from the slave
//   s, mag, neg, ovf : registered result from the slave
interface somador_c2_seq_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] mag;
   logic             neg;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, s, mag, neg, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, s, mag, neg, ovf
   );
endinterface

// File: rtl/somador_c2_seq.sv
// somador_c2_seq: bit-serial two's-complement adder/subtractor, one result bit
// per clock (LSB first), followed by a magnitude/sign/overflow stage and a
// one-cycle done pulse.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : somador_c2_seq_if.slave (start/sub/a/b in; busy/done/s/mag/neg/ovf out)
// Build option: define SOMADOR_C2_SAT_EN to saturate s on signed overflow
// (ovf still reads 1); otherwise s wraps modulo 2^WIDTH.
//
// state | meaning
// IDLE  | waiting for start; also retires busy/done after a finished operation
// ADD   | resolves sum bit cnt with one full adder and the carry flop
// MAG   | registers s, mag, neg, ovf from the finished sum
// DONE  | raises done for one cycle, then back to IDLE
module somador_c2_seq #(
   parameter int WIDTH = 6
) (
   input  logic              clk,
   input  logic              rst,
   somador_c2_seq_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, MAG, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             c_msb;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] s_r;
   logic [WIDTH-1:0] mag_r;
   logic             neg_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic             sum_bit;
   logic             cout;
   logic             ovf_c;
   logic [WIDTH-1:0] s_fin;
   logic [WIDTH-1:0] mag_c;

   always_comb begin
      sum_bit = a_r[cnt] ^ b_r[cnt] ^ carry;
      cout    = (a_r[cnt] & b_r[cnt]) | (carry & (a_r[cnt] ^ b_r[cnt]));
      // In MAG, carry holds the carry out of the MSB and c_msb the carry into it.
      ovf_c   = c_msb ^ carry;
      s_fin   = sum_r;
`ifdef SOMADOR_C2_SAT_EN
      // Both (possibly inverted) operands non-negative means positive overflow.
      if (ovf_c) begin
         if (!a_r[WIDTH-1] && !b_r[WIDTH-1])
            s_fin = {1'b0, {(WIDTH-1){1'b1}}};
         else
            s_fin = {1'b1, {(WIDTH-1){1'b0}}};
      end
`endif
      // Truncation makes the most negative value map to 2^(WIDTH-1) unsigned.
      mag_c = s_fin[WIDTH-1] ? (~s_fin + {{(WIDTH-1){1'b0}}, 1'b1}) : s_fin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         c_msb  <= 1'b0;
         cnt    <= '0;
         s_r    <= '0;
         mag_r  <= '0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // busy still high here means the done pulse is showing;
               // start is ignored for that one cycle.
               if (busy_r) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end else if (bus.start) begin
                  a_r    <= bus.a;
                  b_r    <= bus.b ^ {WIDTH{bus.sub}};
                  carry  <= bus.sub;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= ADD;
               end
            end
            ADD: begin
               sum_r[cnt] <= sum_bit;
               carry      <= cout;
               if (cnt == LAST) begin
                  c_msb <= carry;
                  state <= MAG;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            MAG: begin
               s_r   <= s_fin;
               mag_r <= mag_c;
               neg_r <= s_fin[WIDTH-1];
               ovf_r <= ovf_c;
               state <= DONE;
            end
            DONE: begin
               done_r <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.s    = s_r;
   assign bus.mag  = mag_r;
   assign bus.neg  = neg_r;
   assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_somador_c2_seq.sv
module tb_somador_c2_seq;
   localparam int W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   somador_c2_seq_if #(.WIDTH(W)) bus ();
   somador_c2_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      string          name;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sub;
      logic [W-1:0]   es;
      logic [W-1:0]   emag;
      logic           eneg;
      logic           eovf;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: signed integer arithmetic, then clamp or wrap into WIDTH bits.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] es, output logic [W-1:0] emag,
                                 output logic eneg, output logic eovf);
      int sa, sb, r, lo, hi, m;
      sa = int'($signed(a));
      sb = int'($signed(b));
      lo = -(1 << (W - 1));
      hi = (1 << (W - 1)) - 1;
      r  = sub ? sa - sb : sa + sb;
      eovf = (r > hi) || (r < lo);
`ifdef SOMADOR_C2_SAT_EN
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`else
      if (r > hi) r = r - (1 << W);
      if (r < lo) r = r + (1 << W);
`endif
      es   = r[W-1:0];
      eneg = (r < 0);
      m    = (r < 0) ? -r : r;
      emag = m[W-1:0];
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic [W-1:0] mag,
                         output logic neg, output logic ovf, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.sub   = 1'($urandom);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      s   = bus.s;
      mag = bus.mag;
      neg = bus.neg;
      ovf = bus.ovf;
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("busy_cleared", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] s, mag, es, emag;
      logic         neg, ovf, eneg, eovf;
      int           lat, first, ndone;

      vecs[0] = '{"add_5_3",   6'd5,        6'd3, 1'b0, 6'b001000, 6'd8,  1'b0, 1'b0};
      vecs[1] = '{"sub_3_5",   6'd3,        6'd5, 1'b1, 6'b111110, 6'd2,  1'b1, 1'b0};
`ifdef SOMADOR_C2_SAT_EN
      vecs[2] = '{"ovf_pos",   6'd31,       6'd1, 1'b0, 6'b011111, 6'd31, 1'b0, 1'b1};
      vecs[5] = '{"ovf_neg",   6'b100000,   6'd1, 1'b1, 6'b100000, 6'd32, 1'b1, 1'b1};
`else
      vecs[2] = '{"ovf_pos",   6'd31,       6'd1, 1'b0, 6'b100000, 6'd32, 1'b1, 1'b1};
      vecs[5] = '{"ovf_neg",   6'b100000,   6'd1, 1'b1, 6'b011111, 6'd31, 1'b0, 1'b1};
`endif
      vecs[3] = '{"most_neg",  6'b100000,   6'd0, 1'b0, 6'b100000, 6'd32, 1'b1, 1'b0};
      vecs[4] = '{"zero",      6'd0,        6'd0, 1'b0, 6'd0,      6'd0,  1'b0, 1'b0};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.sub   = 1'b0;
      #2;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_s",    32'(bus.s),    32'd0);
      check("rst_mag",  32'(bus.mag),  32'd0);
      check("rst_neg",  32'(bus.neg),  32'd0);
      check("rst_ovf",  32'(bus.ovf),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, s, mag, neg, ovf, lat);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'd8);
         check({vecs[i].name, "_s"},   32'(s),   32'(vecs[i].es));
         check({vecs[i].name, "_mag"}, 32'(mag), 32'(vecs[i].emag));
         check({vecs[i].name, "_neg"}, 32'(neg), 32'(vecs[i].eneg));
         check({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].eovf));
      end

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic         rsub;
         ra   = W'($urandom);
         rb   = W'($urandom);
         rsub = 1'($urandom);
         model(ra, rb, rsub, es, emag, eneg, eovf);
         run_op(ra, rb, rsub, s, mag, neg, ovf, lat);
         check("rand_lat", 32'(lat), 32'd8);
         check("rand_s",   32'(s),   32'(es));
         check("rand_mag", 32'(mag), 32'(emag));
         check("rand_neg", 32'(neg), 32'(eneg));
         check("rand_ovf", 32'(ovf), 32'(eovf));
      end

      // A second start three cycles into ADD must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 6'd5;
      bus.b = 6'd3;
      bus.sub = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 6'd20;
      bus.b = 6'd7;
      bus.sub = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      first = -1;
      ndone = 0;
      for (int k = 5; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            if (first < 0) begin
               first = k;
               s = bus.s;
            end
         end
      end
      check("restart_lat",   32'(first), 32'd8);
      check("restart_ndone", 32'(ndone), 32'd1);
      check("restart_s",     32'(s),     32'd8);

      // Asynchronous reset mid-ADD; s currently holds 8 from the previous op.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 6'd10;
      bus.b = 6'd7;
      bus.sub = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_s",    32'(bus.s),    32'd0);
      check("arst_mag",  32'(bus.mag),  32'd0);
      check("arst_neg",  32'(bus.neg),  32'd0);
      check("arst_ovf",  32'(bus.ovf),  32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      ndone = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check("arst_no_done", 32'(ndone), 32'd0);
      run_op(6'b111100, 6'b111100, 1'b0, s, mag, neg, ovf, lat);
      check("post_rst_lat", 32'(lat), 32'd8);
      check("post_rst_s",   32'(s),   32'(6'b111000));
      check("post_rst_mag", 32'(mag), 32'd8);
      check("post_rst_neg", 32'(neg), 32'd1);
      check("post_rst_ovf", 32'(ovf), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/somador_c2_seq.md
SOMADOR_C2_SEQ -- requirements
Module: somador_c2_seq

Interface
REQ-001 Parameter WIDTH, default 6: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  two's-complement operand A; sampled with start.
REQ-007 b  input  WIDTH  two's-complement operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress, including the DONE cycle.
REQ-009 done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
REQ-010 s  output  WIDTH  two's-complement result.
REQ-011 mag  output  WIDTH  unsigned magnitude of s, for the display.
REQ-012 neg  output  1  sign of s: 1 = negative.
REQ-013 ovf  output  1  signed overflow of the last operation.

Function
REQ-014 The FSM SHALL have four states: IDLE, ADD, MAG, DONE.
REQ-015 In IDLE with start=1: latch a, b XOR {WIDTH{sub}}, set carry = sub, clear bit counter, go to ADD; otherwise stay in IDLE.
REQ-016 ADD: one bit per cycle, LSB first, one 1-bit full adder plus a carry flop; bit i is resolved in ADD cycle i.
REQ-017 After WIDTH ADD cycles (counter = WIDTH-1): go to MAG.
REQ-018 MAG, single cycle: ovf = carry into MSB XOR carry out of MSB; neg = final s[WIDTH-1]; mag = neg ? (~s + 1) : s, truncated to WIDTH bits.
REQ-019 DONE, single cycle: done=1, then go to IDLE.
REQ-020 Latency: done SHALL be high in the cycle after the (WIDTH+2)th rising edge following the edge that sampled start (for WIDTH=6: exactly 8 edges after start).
REQ-021 start SHALL be ignored while busy=1; a start in the cycle after DONE is accepted.
REQ-022 s, mag, neg and ovf SHALL hold their last values from the end of MAG until the next MAG; they are not updated during ADD.
REQ-023 The most negative value (-2^(WIDTH-1)) SHALL give mag = 2^(WIDTH-1), as an unsigned WIDTH-bit value, with neg=1.
REQ-024 Zero SHALL give mag=0 and neg=0.
REQ-025 Inputs a, b and sub SHALL have no effect after start has been sampled.

Reset
REQ-026 While rst=1, the block SHALL immediately force state=IDLE, busy=0, done=0, s=0, mag=0, neg=0, ovf=0, carry=0 and counter=0, regardless of clk.
REQ-027 A reset during ADD or MAG SHALL abort the operation with no done pulse; the first start after rst falls is accepted normally.

Configuration
REQ-028 Macro SOMADOR_C2_SAT_EN: when defined, overflow SHALL saturate s to 2^(WIDTH-1)-1 for positive overflow (both operands non-negative after B inversion) or to -2^(WIDTH-1) for negative overflow. In that case mag and neg derive from the saturated s, and ovf still reads 1.
REQ-029 When SOMADOR_C2_SAT_EN is undefined, s SHALL wrap modulo 2^WIDTH; ovf behaviour is unchanged.

Verification (WIDTH=6)
REQ-030 a=5, b=3, sub=0 -> 8 edges later done=1, s=001000, mag=8, neg=0, ovf=0.
REQ-031 a=3, b=5, sub=1 -> s=111110, mag=2, neg=1, ovf=0.
REQ-032 a=31, b=1, sub=0 -> ovf=1. Without the macro: s=100000, mag=32, neg=1. With SOMADOR_C2_SAT_EN: s=011111, mag=31, neg=0.
REQ-033 a=-32, b=0, sub=0 -> s=100000, mag=32 (100000), neg=1, ovf=0. a=0, b=0 -> mag=0, neg=0.
REQ-034 Pulse start again 3 cycles into ADD with different operands -> ignored; the result matches the first operands; done pulses exactly once.
REQ-035 Assert rst asynchronously mid-ADD -> all outputs 0 immediately, no done pulse; a following start with a=-4, b=-4, sub=0 -> s=111000, mag=8, neg=1, ovf=0.
